// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase scheduler: state codes,
// default dwell times, lamp bundle and the state-to-lamp decode.
package traffic_pkg;

  localparam int PS_W = 4;

  localparam logic [PS_W-1:0] S_GA    = 4'd0;
  localparam logic [PS_W-1:0] S_YA    = 4'd1;
  localparam logic [PS_W-1:0] S_CLR_A = 4'd2;
  localparam logic [PS_W-1:0] S_GB    = 4'd3;
  localparam logic [PS_W-1:0] S_YB    = 4'd4;
  localparam logic [PS_W-1:0] S_CLR_B = 4'd5;
  localparam logic [PS_W-1:0] S_WALK  = 4'd6;
  localparam logic [PS_W-1:0] S_CLR_W = 4'd7;

  localparam int T_MIN_GREEN_DEF = 6;
  localparam int T_MAX_GREEN_DEF = 12;
  localparam int T_YELLOW_DEF    = 2;
  localparam int T_ALLRED_DEF    = 1;
  localparam int T_WALK_DEF      = 4;
  localparam int CNT_W_DEF       = 4;

  typedef enum logic {STREET_A, STREET_B} street_t;

  typedef struct packed {
    logic ga;
    logic ya;
    logic ra;
    logic gb;
    logic yb;
    logic rb;
    logic walk;
  } lamps_t;

  function automatic lamps_t decode_lamps(input logic [PS_W-1:0] ps);
    lamps_t l;
    l = '0;
    case (ps)
      S_GA:    begin l.ga = 1'b1; l.rb = 1'b1; end
      S_YA:    begin l.ya = 1'b1; l.rb = 1'b1; end
      S_GB:    begin l.ra = 1'b1; l.gb = 1'b1; end
      S_YB:    begin l.ra = 1'b1; l.yb = 1'b1; end
      S_WALK:  begin l.ra = 1'b1; l.rb = 1'b1; l.walk = 1'b1; end
      // clearance states and illegal codes both show all-red
      default: begin l.ra = 1'b1; l.rb = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_sched_if.sv
// Sensor/request inputs, lamp outputs and present-state bus of the scheduler.
interface traffic_sched_if;
  import traffic_pkg::*;

  logic            Sa;
  logic            Sb;
  logic            Pr;
  logic            Ga;
  logic            Ya;
  logic            Ra;
  logic            Gb;
  logic            Yb;
  logic            Rb;
  logic            Walk;
  logic [PS_W-1:0] PS;

  modport master (output Sa, Sb, Pr, input Ga, Ya, Ra, Gb, Yb, Rb, Walk, PS);
  modport slave  (input Sa, Sb, Pr, output Ga, Ya, Ra, Gb, Yb, Rb, Walk, PS);

endinterface

// File: rtl/traffic_sched_phase_timer.sv
// Phase dwell timer: saturating up-counter with synchronous clear.
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic [CNT_W-1:0] t
);

  always_ff @(posedge clk) begin
    if (reset || clr) t <= '0;
    else if (t != '1) t <= t + CNT_W'(1);
  end

endmodule

// File: rtl/traffic_sched.sv
// Two-street phase scheduler with optional pedestrian walk phase.
// Walk phase is built only when TRAFFIC_PED_WALK_EN is defined.
module traffic_sched
  import traffic_pkg::*;
#(
  parameter int T_MIN_GREEN = T_MIN_GREEN_DEF,
  parameter int T_MAX_GREEN = T_MAX_GREEN_DEF,
  parameter int T_YELLOW    = T_YELLOW_DEF,
  parameter int T_ALLRED    = T_ALLRED_DEF,
  parameter int T_WALK      = T_WALK_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  traffic_sched_if.slave bus
);

  // state   | meaning
  // GA      | street A green, B red
  // YA      | street A yellow
  // CLR_A   | all-red after A
  // GB      | street B green, A red
  // YB      | street B yellow
  // CLR_B   | all-red after B
  // WALK    | all-red, walk lamp on
  // CLR_W   | all-red after walk

`ifdef TRAFFIC_PED_WALK_EN
  localparam logic PED_EN = 1'b1;
`else
  localparam logic PED_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] TC_MIN  = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] TC_MAX  = CNT_W'(T_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] TC_Y    = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] TC_AR   = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] TC_WALK = CNT_W'(T_WALK - 1);

  logic [PS_W-1:0]  state;
  logic [PS_W-1:0]  state_next;
  logic [CNT_W-1:0] t;
  logic             ped_pend;
  logic             demand_a;
  logic             demand_b;
  street_t          last_green;
  lamps_t           lamps;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state_next != state),
    .t     (t)
  );

  assign demand_a = bus.Sa | ped_pend;
  assign demand_b = bus.Sb | ped_pend;

  always_comb begin
    state_next = state;
    case (state)
      S_GA:
        if (demand_b && ((t >= TC_MIN && !bus.Sa) || t >= TC_MAX)) state_next = S_YA;
      S_YA:
        if (t == TC_Y) state_next = S_CLR_A;
      S_CLR_A:
        if (t == TC_AR) state_next = ped_pend ? S_WALK : S_GB;
      S_GB:
        if (demand_a && ((t >= TC_MIN && !bus.Sb) || t >= TC_MAX)) state_next = S_YB;
      S_YB:
        if (t == TC_Y) state_next = S_CLR_B;
      S_CLR_B:
        if (t == TC_AR) state_next = ped_pend ? S_WALK : S_GA;
      S_WALK:
        if (!PED_EN) state_next = S_GA;
        else if (t == TC_WALK) state_next = S_CLR_W;
      S_CLR_W:
        if (!PED_EN) state_next = S_GA;
        else if (t == TC_AR) begin
          if (last_green == STREET_A) state_next = bus.Sb ? S_GB : S_GA;
          else                        state_next = bus.Sa ? S_GA : S_GB;
        end
      default:
        state_next = S_GA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_GA;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset)                                      last_green <= STREET_A;
    else if (state_next == S_GA && state != S_GA)   last_green <= STREET_A;
    else if (state_next == S_GB && state != S_GB)   last_green <= STREET_B;
  end

`ifdef TRAFFIC_PED_WALK_EN
  // entry into WALK serves the request; Pr during WALK is not re-latched
  always_ff @(posedge clk) begin
    if (reset)                                          ped_pend <= 1'b0;
    else if (state_next == S_WALK && state != S_WALK)   ped_pend <= 1'b0;
    else if (bus.Pr && state != S_WALK)                 ped_pend <= 1'b1;
  end
`else
  logic unused_pr;
  assign unused_pr = bus.Pr;
  assign ped_pend  = 1'b0;
`endif

  always_comb lamps = decode_lamps(state);

  assign bus.Ga   = lamps.ga;
  assign bus.Ya   = lamps.ya;
  assign bus.Ra   = lamps.ra;
  assign bus.Gb   = lamps.gb;
  assign bus.Yb   = lamps.yb;
  assign bus.Rb   = lamps.rb;
  assign bus.Walk = lamps.walk & PED_EN;
  assign bus.PS   = state;

endmodule

// File: tb/tb_traffic_sched.sv
// Self-checking bench for traffic_sched: vector table plus hand-written
// pedestrian/reset sequences, checked through an expected-value queue.
module tb_traffic_sched;

  typedef struct {
    logic       rst;
    logic       sa;
    logic       sb;
    logic       pr;
    int         n;
    logic [3:0] ps;
  } vec_t;

  typedef struct {
    logic [3:0] ps;
    logic [6:0] lamps;
  } exp_t;

  localparam logic [3:0] GA = 4'd0, YA = 4'd1, CLR_A = 4'd2, GB = 4'd3;
  localparam logic [3:0] YB = 4'd4, CLR_B = 4'd5, WALK = 4'd6, CLR_W = 4'd7;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];
  vec_t tbl[$];

  traffic_sched_if bus();

  traffic_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {Ga,Ya,Ra,Gb,Yb,Rb,Walk}
  function automatic logic [6:0] lamps_ref(input logic [3:0] ps);
    case (ps)
      4'd0:    return 7'b1000010;
      4'd1:    return 7'b0100010;
      4'd3:    return 7'b0011000;
      4'd4:    return 7'b0010100;
      4'd6:    return 7'b0010011;
      default: return 7'b0010010;
    endcase
  endfunction

  function automatic vec_t mk(input logic r, sa, sb, pr, input int n, input logic [3:0] ps);
    vec_t v;
    v.rst = r; v.sa = sa; v.sb = sb; v.pr = pr; v.n = n; v.ps = ps;
    return v;
  endfunction

  task automatic check_out();
    exp_t       e;
    logic [6:0] act;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: no expected entry at %0t", $time);
      return;
    end
    e = sb_q.pop_front();
    if (bus.PS !== e.ps) begin
      bad++;
      $display("FAIL ps at %0t: actual=%0d required=%0d", $time, bus.PS, e.ps);
    end
    act = {bus.Ga, bus.Ya, bus.Ra, bus.Gb, bus.Yb, bus.Rb, bus.Walk};
    total++;
    if (act !== e.lamps) begin
      bad++;
      $display("FAIL lamps at %0t (ps=%0d): actual=%b required=%b", $time, e.ps, act, e.lamps);
    end
  endtask

  task automatic step(input logic r, sa, sb, pr, input logic [3:0] ps);
    exp_t e;
    reset  = r;
    bus.Sa = sa;
    bus.Sb = sb;
    bus.Pr = pr;
    e.ps    = ps;
    e.lamps = lamps_ref(ps);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic run_tbl();
    foreach (tbl[i])
      for (int k = 0; k < tbl[i].n; k++)
        step(tbl[i].rst, tbl[i].sa, tbl[i].sb, tbl[i].pr, tbl[i].ps);
    tbl.delete();
  endtask

  initial begin
    reset  = 1'b1;
    bus.Sa = 1'b0;
    bus.Sb = 1'b0;
    bus.Pr = 1'b0;

    // B demand only: GA 6, YA 2, CLR_A 1, GB on the 9th edge; then rest,
    // saturated-timer decision, and a sensor drop during yellow.
    tbl.push_back(mk(1, 0, 0, 0, 2, GA));
    tbl.push_back(mk(0, 0, 1, 0, 5, GA));
    tbl.push_back(mk(0, 0, 1, 0, 2, YA));
    tbl.push_back(mk(0, 0, 1, 0, 1, CLR_A));
    tbl.push_back(mk(0, 0, 1, 0, 1, GB));
    tbl.push_back(mk(0, 0, 1, 0, 20, GB));
    tbl.push_back(mk(0, 1, 1, 0, 1, YB));
    tbl.push_back(mk(0, 0, 0, 0, 1, YB));
    tbl.push_back(mk(0, 0, 0, 0, 1, CLR_B));
    tbl.push_back(mk(0, 0, 0, 0, 5, GA));
    // both streets busy: max-green rotation with period 30
    tbl.push_back(mk(1, 1, 1, 0, 1, GA));
    tbl.push_back(mk(0, 1, 1, 0, 11, GA));
    tbl.push_back(mk(0, 1, 1, 0, 2, YA));
    tbl.push_back(mk(0, 1, 1, 0, 1, CLR_A));
    tbl.push_back(mk(0, 1, 1, 0, 12, GB));
    tbl.push_back(mk(0, 1, 1, 0, 2, YB));
    tbl.push_back(mk(0, 1, 1, 0, 1, CLR_B));
    tbl.push_back(mk(0, 1, 1, 0, 12, GA));
    tbl.push_back(mk(0, 1, 1, 0, 2, YA));
    // no demand for 50 cycles, then demand against a long-saturated timer
    tbl.push_back(mk(1, 0, 0, 0, 1, GA));
    tbl.push_back(mk(0, 0, 0, 0, 50, GA));
    tbl.push_back(mk(0, 1, 1, 0, 2, YA));
    tbl.push_back(mk(0, 1, 1, 0, 1, CLR_A));
    tbl.push_back(mk(0, 1, 1, 0, 1, GB));
    run_tbl();

`ifdef TRAFFIC_PED_WALK_EN
    // pedestrian pulse in a quiet GA
    step(1, 0, 0, 0, GA);
    step(0, 0, 0, 0, GA);
    step(0, 0, 0, 1, GA);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, GA);
    for (int k = 0; k < 2; k++) step(0, 0, 0, 0, YA);
    step(0, 0, 0, 0, CLR_A);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, WALK);
    step(0, 0, 0, 0, CLR_W);
    for (int k = 0; k < 2; k++) step(0, 0, 0, 0, GA);

    // reset in YB with a pending request discards it
    step(1, 0, 0, 0, GA);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, GA);
    for (int k = 0; k < 2; k++) step(0, 0, 1, 0, YA);
    step(0, 0, 1, 0, CLR_A);
    step(0, 0, 1, 0, GB);
    step(0, 0, 0, 1, GB);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, GB);
    step(0, 0, 0, 0, YB);
    step(1, 0, 1, 0, GA);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, GA);
    for (int k = 0; k < 2; k++) step(0, 0, 1, 0, YA);
    step(0, 0, 1, 0, CLR_A);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, GB);
`else
    // pedestrian requests have no effect without the walk phase
    step(1, 0, 0, 0, GA);
    for (int k = 0; k < 20; k++) step(0, 0, 0, k[0], GA);
    for (int k = 0; k < 2; k++) step(0, 0, 1, 1, YA);
    step(0, 0, 1, 1, CLR_A);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 1, GB);
`endif

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: actual=%0d left required=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
